// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification, retry/fault and core reset release
module pll_reset_sequencer #(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 742500,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 20
) (
  input  logic       refclk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       req_reconfig,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       sys_ready,
  output logic       lock_lost,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  // Terminal counts are compared against "last cycle" values so each phase lasts exactly N cycles.
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
  localparam logic [2:0]       MAX_R3       = 3'(MAX_RETRIES);
  localparam logic [1:0]       MAX_R2       = 2'(MAX_RETRIES);

  logic             meta_q;
  logic             locked_sync_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             lost_d;
  logic             pll_rst_q, core_reset_n_q, sys_ready_q, lock_lost_q, fault_q;

  // Two-flop synchroniser: pll_locked is asynchronous to refclk.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q        <= 1'b0;
      locked_sync_q <= 1'b0;
    end else begin
      meta_q        <= pll_locked;
      locked_sync_q <= meta_q;
    end
  end

  // Next-state, counter and event-counter decisions; reconfig outranks lock status except in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    retry_d = retry_q;
    loss_d  = loss_q;
    lost_d  = 1'b0;
    case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end
      end
      S_WAIT_LOCK: begin
        if (req_reconfig) begin
          state_d = S_RESET_PLL;
          cnt_d   = CNT_ZERO;
        end else if (locked_sync_q) begin
          state_d = S_STABILIZE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = CNT_ZERO;
          if (({1'b0, retry_q} + 3'd1) >= MAX_R3) begin
            retry_d = MAX_R2;
            state_d = S_FAULT;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = S_RESET_PLL;
          end
        end
      end
      S_STABILIZE: begin
        if (req_reconfig) begin
          state_d = S_RESET_PLL;
          cnt_d   = CNT_ZERO;
        end else if (!locked_sync_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = CNT_ZERO;
          retry_d = 2'd0;
        end
      end
      S_RUN: begin
        cnt_d = CNT_ZERO;
        if (!locked_sync_q) begin
          state_d = S_RESET_PLL;
          lost_d  = 1'b1;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end else if (req_reconfig) begin
          state_d = S_RESET_PLL;
        end
      end
      S_FAULT: begin
        cnt_d = CNT_ZERO;
        if (req_reconfig) begin
          state_d = S_RESET_PLL;
          retry_d = 2'd0;
        end
      end
      default: begin
        state_d = S_RESET_PLL;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State register with outputs decoded from the next state so they move on the same edge.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_RESET_PLL;
      cnt_q          <= CNT_ZERO;
      retry_q        <= 2'd0;
      loss_q         <= 8'd0;
      pll_rst_q      <= 1'b1;
      core_reset_n_q <= 1'b0;
      sys_ready_q    <= 1'b0;
      lock_lost_q    <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      loss_q         <= loss_d;
      pll_rst_q      <= (state_d == S_RESET_PLL);
      core_reset_n_q <= (state_d == S_RUN);
      sys_ready_q    <= (state_d == S_RUN);
      lock_lost_q    <= lost_d;
      fault_q        <= (state_d == S_FAULT);
    end
  end

  assign pll_rst         = pll_rst_q;
  assign core_reset_n    = core_reset_n_q;
  assign sys_ready       = sys_ready_q;
  assign lock_lost       = lock_lost_q;
  assign fault           = fault_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;
  assign state           = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

  localparam int H = 4;
  localparam int S = 8;
  localparam int T = 32;
  localparam int M = 2;

  localparam int P_RST   = 0;
  localparam int P_WAIT  = 1;
  localparam int P_STAB  = 2;
  localparam int P_RUN   = 3;
  localparam int P_FAULT = 4;

  logic       refclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       req_reconfig = 1'b0;
  logic       pll_rst, core_reset_n, sys_ready, lock_lost, fault;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES(H),
    .LOCK_STABLE_CYCLES(S),
    .LOCK_TIMEOUT_CYCLES(T),
    .MAX_RETRIES(M),
    .CNT_W(6)
  ) dut (
    .refclk(refclk),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .req_reconfig(req_reconfig),
    .pll_rst(pll_rst),
    .core_reset_n(core_reset_n),
    .sys_ready(sys_ready),
    .lock_lost(lock_lost),
    .fault(fault),
    .retry_count(retry_count),
    .lock_loss_count(lock_loss_count),
    .state(state)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase plus cycles spent in it; locked seen by the FSM is the pin two edges ago.
  int ph, n, retries, losses;
  int m_nx;
  bit m_ls;
  bit lost;
  bit lsq[$];

  task automatic model_reset();
    ph = P_RST; n = 0; retries = 0; losses = 0; lost = 0;
    lsq = '{1'b0, 1'b0};
  endtask

  initial model_reset();

  always @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      m_ls = lsq.pop_front();
      lsq.push_back(pll_locked);
      lost = 0;
      m_nx = ph;
      case (ph)
        P_RST: begin n++; if (n == H) m_nx = P_WAIT; end
        P_WAIT: begin
          if (req_reconfig) m_nx = P_RST;
          else if (m_ls) m_nx = P_STAB;
          else begin
            n++;
            if (n == T) begin
              if (retries < M) retries++;
              m_nx = (retries >= M) ? P_FAULT : P_RST;
            end
          end
        end
        P_STAB: begin
          if (req_reconfig) m_nx = P_RST;
          else if (!m_ls) m_nx = P_WAIT;
          else begin
            n++;
            if (n == S) begin m_nx = P_RUN; retries = 0; end
          end
        end
        P_RUN: begin
          if (!m_ls) begin
            lost = 1;
            if (losses < 255) losses++;
            m_nx = P_RST;
          end else if (req_reconfig) m_nx = P_RST;
        end
        default: begin
          if (req_reconfig) begin retries = 0; m_nx = P_RST; end
        end
      endcase
      if (m_nx != ph) begin ph = m_nx; n = 0; end
    end
  end

  // Per-cycle comparison of every output against the model, away from the clock edge.
  initial begin
    forever begin
      @(posedge refclk);
      #3;
      chk("cyc_state", int'(state), ph);
      chk("cyc_pll_rst", int'(pll_rst), (ph == P_RST) ? 1 : 0);
      chk("cyc_core_reset_n", int'(core_reset_n), (ph == P_RUN) ? 1 : 0);
      chk("cyc_sys_ready", int'(sys_ready), (ph == P_RUN) ? 1 : 0);
      chk("cyc_fault", int'(fault), (ph == P_FAULT) ? 1 : 0);
      chk("cyc_lock_lost", int'(lock_lost), int'(lost));
      chk("cyc_retry_count", int'(retry_count), retries);
      chk("cyc_lock_loss_count", int'(lock_loss_count), losses);
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge refclk);
  endtask

  task automatic wait_state(input int s, input int budget);
    int c;
    c = 0;
    while (int'(state) != s && c < budget) begin
      @(negedge refclk);
      c++;
    end
    chk("wait_state_reached", int'(state), s);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_pll_rst"}, int'(pll_rst), 1);
    chk({tag, "_core_reset_n"}, int'(core_reset_n), 0);
    chk({tag, "_sys_ready"}, int'(sys_ready), 0);
    chk({tag, "_lock_lost"}, int'(lock_lost), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_retry_count"}, int'(retry_count), 0);
    chk({tag, "_lock_loss_count"}, int'(lock_loss_count), 0);
  endtask

  initial begin
    int c;
    tick(2);
    chk_reset_values("reset");

    // 1: pll_rst high for exactly H edges after release
    reset_n = 1'b1;
    for (int i = 1; i <= H; i++) begin
      tick(1);
      chk("t1_pll_rst", int'(pll_rst), (i < H) ? 1 : 0);
    end
    chk("t1_state", int'(state), 1);
    chk("t1_core_reset_n", int'(core_reset_n), 0);

    // 2: lock at edge N -> STABILIZE at N+2, RUN at N+10
    tick(3);
    pll_locked = 1'b1;
    tick(3);  chk("t2_stab_at_n2", int'(state), 2);
    tick(7);  chk("t2_stab_at_n9", int'(state), 2);
              chk("t2_core_n9", int'(core_reset_n), 0);
    tick(1);  chk("t2_run_at_n10", int'(state), 3);
              chk("t2_core_n10", int'(core_reset_n), 1);
              chk("t2_ready_n10", int'(sys_ready), 1);
              chk("t2_retry", int'(retry_count), 0);

    // 6a: reconfig in RUN with lock held
    req_reconfig = 1'b1; tick(1); req_reconfig = 1'b0;
    chk("t6a_state", int'(state), 0);
    chk("t6a_lock_lost", int'(lock_lost), 0);
    chk("t6a_loss_count", int'(lock_loss_count), 0);
    chk("t6a_pll_rst", int'(pll_rst), 1);
    pll_locked = 1'b0;
    wait_state(1, 50);

    // 3: one-cycle dropout on the 5th STABILIZE cycle
    pll_locked = 1'b1; tick(5);
    pll_locked = 1'b0; tick(1);
    pll_locked = 1'b1; tick(1);
    chk("t3_stab_n6", int'(state), 2);
    tick(1); chk("t3_wait_n7", int'(state), 1);
             chk("t3_core_n7", int'(core_reset_n), 0);
    tick(1); chk("t3_stab_n8", int'(state), 2);
    tick(7); chk("t3_stab_n15", int'(state), 2);
    tick(1); chk("t3_run_n16", int'(state), 3);

    // 5: single lock loss in RUN
    pll_locked = 1'b0; tick(3);
    chk("t5_lock_lost", int'(lock_lost), 1);
    chk("t5_state", int'(state), 0);
    chk("t5_pll_rst", int'(pll_rst), 1);
    chk("t5_core", int'(core_reset_n), 0);
    chk("t5_loss_count", int'(lock_loss_count), 1);
    tick(1); chk("t5_pulse_end", int'(lock_lost), 0);

    // 4: two timeouts -> FAULT, then reconfig clears it
    wait_state(1, 50);
    wait_state(0, 100);
    chk("t4_retry1", int'(retry_count), 1);
    c = 0;
    while (pll_rst && c < 20) begin c++; tick(1); end
    chk("t4_rst_len", c, H);
    wait_state(4, 100);
    chk("t4_fault", int'(fault), 1);
    chk("t4_retry2", int'(retry_count), 2);
    chk("t4_pll_rst", int'(pll_rst), 0);
    chk("t4_core", int'(core_reset_n), 0);
    tick(5); chk("t4_fault_held", int'(fault), 1);
    req_reconfig = 1'b1; tick(1); req_reconfig = 1'b0;
    chk("t4_fault_clr", int'(fault), 0);
    chk("t4_retry_clr", int'(retry_count), 0);
    chk("t4_pll_rst_on", int'(pll_rst), 1);

    // 6b: reconfig coincident with lock loss counts as lock loss
    pll_locked = 1'b1;
    wait_state(3, 100);
    pll_locked = 1'b0; tick(2);
    req_reconfig = 1'b1; tick(1); req_reconfig = 1'b0;
    chk("t6b_lock_lost", int'(lock_lost), 1);
    chk("t6b_loss_count", int'(lock_loss_count), 2);
    chk("t6b_state", int'(state), 0);

    // 5b: repeated losses saturate the counter
    for (int i = 0; i < 256; i++) begin
      pll_locked = 1'b1;
      wait_state(3, 100);
      pll_locked = 1'b0;
      tick(3);
    end
    chk("t5_sat_count", int'(lock_loss_count), 255);
    chk("t5_sat_pulse", int'(lock_lost), 1);

    // 6c: asynchronous reset mid-STABILIZE
    pll_locked = 1'b1;
    wait_state(2, 50);
    tick(2);
    chk("t6c_in_stab", int'(state), 2);
    #2 reset_n = 1'b0;
    #1 chk_reset_values("t6c_async");
    tick(2);
    reset_n = 1'b1;
    wait_state(3, 50);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sequences the board PLL wrapper. Pulses its rst input, waits for `locked`, and qualifies lock stability.
- Releases the downstream core reset only after the lock has been stable for a set time.
- Retries when lock fails to arrive, recovers automatically if lock is lost, and latches a fault after repeated failures.
- Runs on the free-running reference clock, because PLL output clocks are not valid until lock.

Parameters:
- RST_HOLD_CYCLES, 16, refclk cycles that pll_rst is held high per reset attempt (minimum 1).
- LOCK_STABLE_CYCLES, 1024, consecutive cycles locked_sync must stay high before release (minimum 1).
- LOCK_TIMEOUT_CYCLES, 742500, cycles allowed in WAIT_LOCK before a retry (10 ms at 74.25 MHz).
- MAX_RETRIES, 3, failed lock attempts that cause FAULT (minimum 1).
- CNT_W, 20, width of the shared cycle counter; must hold the largest of the three cycle parameters minus 1.

Ports:
- refclk  in  1  reference clock, free-running.
- reset_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL locked output; asynchronous to refclk.
- req_reconfig  in  1  single-cycle request to force a full PLL re-lock.
- pll_rst  out  1  drives the PLL rst input, active high.
- core_reset_n  out  1  active-low reset for PLL-clocked logic.
- sys_ready  out  1  high only in RUN.
- lock_lost  out  1  one-cycle pulse when lock drops in RUN.
- fault  out  1  high in FAULT.
- retry_count  out  2  failed attempts since the last successful lock.
- lock_loss_count  out  8  saturating count of lock-loss events.
- state  out  3  debug: 0 RESET_PLL, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN, 4 FAULT.

Behaviour:
- Reset and clocking:
  - One clock, refclk. reset_n is asynchronous and active-low.
  - All outputs are registered and change on the same edge as the state register.
- Reset values: state RESET_PLL, counter 0, pll_rst 1, core_reset_n 0, sys_ready 0, lock_lost 0, fault 0, retry_count 0, lock_loss_count 0. The synchroniser flops reset to 0.
- Synchroniser: pll_locked passes through a 2-flop synchroniser to produce locked_sync. The FSM uses only locked_sync, so pin-to-FSM latency is 2 edges.
- RESET_PLL:
  - pll_rst=1; the counter increments.
  - When counter==RST_HOLD_CYCLES-1, go to WAIT_LOCK and clear the counter. pll_rst is high for exactly RST_HOLD_CYCLES cycles.
  - req_reconfig is ignored in this state.
- WAIT_LOCK:
  - pll_rst=0.
  - locked_sync=1: go to STABILIZE, counter cleared.
  - Otherwise, when counter==LOCK_TIMEOUT_CYCLES-1, increment retry_count. If the new value equals MAX_RETRIES, go to FAULT; else go to RESET_PLL. Counter cleared either way.
- STABILIZE:
  - locked_sync=0 on any cycle: go to WAIT_LOCK with the counter cleared. The timeout restarts and retry_count is unchanged.
  - locked_sync=1 and counter==LOCK_STABLE_CYCLES-1: go to RUN and clear retry_count.
- RUN:
  - core_reset_n=1, sys_ready=1.
  - locked_sync=0: go to RESET_PLL. lock_lost pulses for 1 cycle on the transition edge, and lock_loss_count increments, saturating at 255. core_reset_n and sys_ready drop on the same edge.
  - req_reconfig=1 with locked_sync=1: go to RESET_PLL with no lock_lost pulse and no count.
  - Simultaneous lock loss and req_reconfig: treated as a lock loss, so the pulse and count apply.
- FAULT:
  - fault=1, pll_rst=0, core_reset_n=0.
  - Held until reset_n or req_reconfig. req_reconfig clears fault and retry_count and goes to RESET_PLL.
- req_reconfig in WAIT_LOCK or STABILIZE: go to RESET_PLL, counter cleared, retry_count unchanged.
- core_reset_n is never 1 outside RUN. An asynchronous reset at any point immediately forces all reset values.
- retry_count saturates at MAX_RETRIES and lock_loss_count saturates at 255; neither wraps.

Test Plan:
Bench parameters: RST_HOLD_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
1. Reset release with pll_locked=0 -> pll_rst=1 for exactly 4 edges, then 0; state=1; core_reset_n=0.
2. pll_locked rises at edge N in WAIT_LOCK -> STABILIZE at N+2; RUN, core_reset_n=1 and sys_ready=1 at N+10; retry_count=0.
3. pll_locked drops for 1 cycle on the 5th STABILIZE cycle -> returns to WAIT_LOCK; core_reset_n stays 0; a full 8-cycle stable window is required again.
4. pll_locked held 0 -> after 32 WAIT_LOCK cycles retry_count=1 and pll_rst pulses 4 cycles; after the second timeout state=4, fault=1, retry_count=2, pll_rst=0. Then req_reconfig -> fault=0, retry_count=0, pll_rst=1.
5. Lock loss in RUN: pll_locked falls -> 2 edges later lock_lost=1 for one cycle, core_reset_n=0, pll_rst=1, lock_loss_count=1. Repeat 256 times -> lock_loss_count=255.
6. req_reconfig in RUN with lock held -> RESET_PLL with no lock_lost pulse. req_reconfig in the same cycle as locked_sync falling -> lock_lost pulses and the count increments. reset_n asserted mid-STABILIZE -> all outputs take their reset values asynchronously.
